// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int RR_MAX_REQ = 8;
    localparam int RR_IDX_W   = 3;

    // First set bit of valid_vec after last, wrapping modulo n; returns last when none is set.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_IDX_W-1:0]   last,
        input logic [RR_MAX_REQ-1:0] valid_vec,
        input int unsigned           n
    );
        logic [RR_IDX_W-1:0] pick;
        logic [RR_IDX_W-1:0] idx;
        logic                found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
            idx = RR_IDX_W'((32'(last) + i) % n);
            if ((i <= n) && !found && valid_vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_chk.sv
// Write-port safety invariants of fifo_wr_arbiter, checked every clock out of reset.
module fifo_wr_arbiter_chk #(
    parameter int N_REQ = 4
) (
    input logic             clk,
    input logic             rst_n,
    input logic [N_REQ-1:0] req_valid,
    input logic [N_REQ-1:0] req_ready,
    input logic             fifo_full,
    input logic             fifo_wr_en,
    input logic             busy
);

    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr_en && fifo_full));

    a_single_ready: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_wr_is_handshake: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_wr_en == |(req_valid & req_ready));

    a_idle_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !busy |-> (req_ready == {N_REQ{1'b0}}));

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after 'last', wrapping.
// Kept generic so the read-side scheduler can reuse it.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  idx,
    output logic             any_valid
);

    logic [RR_MAX_REQ-1:0] valid_ext_s;
    logic [RR_IDX_W-1:0]   last_ext_s;

    // Widen operands to the helper's fixed sizes and pick the next index.
    always_comb begin
        valid_ext_s            = {RR_MAX_REQ{1'b0}};
        last_ext_s             = {RR_IDX_W{1'b0}};
        valid_ext_s[N_REQ-1:0] = valid;
        last_ext_s[ID_W-1:0]   = last;
        idx                    = ID_W'(rr_next(last_ext_s, valid_ext_s, N_REQ));
        any_valid              = |valid;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst lock sharing one synchronous-FIFO write port
// among N_REQ requesters; never asserts fifo_wr_en while fifo_full is high.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int N_REQ      = 4,
    parameter  int MAX_BURST  = 4,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_din,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy
);

    // One extra bit so the last-beat compare never sees a wrapped count.
    localparam int                CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(N_REQ - 1);

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    logic [ID_W-1:0]       owner_r;
    logic [ID_W-1:0]       owner_nxt_s;
    logic [ID_W-1:0]       last_owner_r;
    logic [ID_W-1:0]       last_owner_nxt_s;
    logic [CNT_W-1:0]      burst_cnt_r;
    logic [CNT_W-1:0]      burst_cnt_nxt_s;
    logic [ID_W-1:0]       pick_idx_s;
    logic                  pick_any_s;
    logic                  owner_valid_s;
    logic [DATA_WIDTH-1:0] owner_data_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .valid     (req_valid),
        .last      (last_owner_r),
        .idx       (pick_idx_s),
        .any_valid (pick_any_s)
    );

    assign owner_valid_s = req_valid[owner_r];
    assign owner_data_s  = req_data[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];

    // Next-state logic and write-port outputs; outputs are quiet outside LOCK.
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        last_owner_nxt_s = last_owner_r;
        burst_cnt_nxt_s  = burst_cnt_r;
        req_ready        = {N_REQ{1'b0}};
        fifo_wr_en       = 1'b0;
        fifo_din         = {DATA_WIDTH{1'b0}};
        grant_id         = {ID_W{1'b0}};
        busy             = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s     = ARB_LOCK;
                    owner_nxt_s     = pick_idx_s;
                    burst_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s     = ARB_IDLE;
                end
            end
            ARB_LOCK: begin
                busy               = 1'b1;
                grant_id           = owner_r;
                fifo_din           = owner_data_s;
                req_ready[owner_r] = ~fifo_full;
                fifo_wr_en         = owner_valid_s & ~fifo_full;
                if (!owner_valid_s) begin
                    // Owner dropped valid: give the port up without a beat.
                    state_nxt_s      = ARB_IDLE;
                    last_owner_nxt_s = owner_r;
                end else if (!fifo_full) begin
                    if (burst_cnt_r == LAST_BEAT) begin
                        state_nxt_s      = ARB_IDLE;
                        last_owner_nxt_s = owner_r;
                    end else begin
                        burst_cnt_nxt_s  = burst_cnt_r + CNT_W'(1);
                    end
                end else begin
                    // FIFO full: stall with the grant and count held.
                    state_nxt_s      = ARB_LOCK;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State, owner and burst counter; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ARB_IDLE;
            owner_r      <= {ID_W{1'b0}};
            last_owner_r <= LAST_IDX;
            burst_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_owner_r <= last_owner_nxt_s;
            burst_cnt_r  <= burst_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: per-cycle reference model of the grant
// rules plus a depth-8 FIFO model and per-requester ordering scoreboard.
module tb_fifo_wr_arbiter;

    localparam int DW    = 32;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int IW    = 2;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           fifo_full;
    logic           fifo_wr_en;
    logic [DW-1:0]  fifo_din;
    logic [IW-1:0]  grant_id;
    logic           busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
    );

    fifo_wr_arbiter_chk #(.N_REQ(NR)) chk (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] txq  [NR][$];
    logic [DW-1:0] expq [NR][$];
    logic [DW-1:0] fifo_q [$];
    int            beat_log [$];
    int            seq [NR];
    logic [NR-1:0] act = {NR{1'b0}};
    logic [NR-1:0] en  = {NR{1'b1}};
    int            pct = 100;
    int            mode = 0;
    logic          full_force = 1'b0;
    logic          rst_req_n  = 1'b0;
    logic          drain_ph   = 1'b0;

    // Reference model: is a grant open, to whom, beats so far, previous owner.
    logic m_open  = 1'b0;
    int   m_who   = 0;
    int   m_beats = 0;
    int   m_prev  = NR - 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_model(input int prev, input logic [NR-1:0] v);
        for (int i = 1; i <= NR; i++) begin
            if (v[(prev + i) % NR]) return (prev + i) % NR;
        end
        return prev;
    endfunction

    function automatic int pending();
        int n;
        n = fifo_q.size();
        for (int k = 0; k < NR; k++) n += txq[k].size();
        return n;
    endfunction

    task automatic add_words(input int k, input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {8'(k), 24'(seq[k])};
            seq[k]++;
            txq[k].push_back(w);
            expq[k].push_back(w);
        end
    endtask

    // One clock: drive at negedge, check and update models 2ns later.
    task automatic cycle();
        logic [NR-1:0] exp_rdy;
        logic [DW-1:0] exp_din;
        logic [DW-1:0] w;
        int src;
        @(negedge clk);
        rst_n = rst_req_n;
        for (int k = 0; k < NR; k++) begin
            if (!act[k] && en[k] && txq[k].size() > 0 && int'($urandom_range(99)) < pct)
                act[k] = 1'b1;
            req_valid[k] = act[k];
            req_data[k*DW +: DW] = act[k] ? txq[k][0] : $urandom;
        end
        case (mode)
            2:       fifo_full = (fifo_q.size() >= DEPTH);
            1:       fifo_full = full_force;
            default: fifo_full = 1'b0;
        endcase
        #2;
        if (fifo_q.size() > 0 && (mode != 2 || drain_ph)) begin
            w   = fifo_q.pop_front();
            src = int'(w[31:24]);
            if (src < NR && expq[src].size() > 0)
                check_eq("sb_data", w, expq[src].pop_front());
            else
                check_eq("sb_unexpected", w, {DW{1'bx}});
        end
        drain_ph = ~drain_ph;
        if (rst_n) begin
            exp_rdy = {NR{1'b0}};
            if (m_open && !fifo_full) exp_rdy[m_who] = 1'b1;
            exp_din = m_open ? req_data[m_who*DW +: DW] : {DW{1'b0}};
            check_eq("busy", busy, m_open);
            check_eq("grant_id", grant_id, m_open ? m_who : 0);
            check_eq("req_ready", req_ready, exp_rdy);
            check_eq("fifo_wr_en", fifo_wr_en, m_open && req_valid[m_who] && !fifo_full);
            check_eq("fifo_din", fifo_din, exp_din);
            check_eq("wr_while_full", fifo_wr_en & fifo_full, 1'b0);
            if (fifo_wr_en) begin
                fifo_q.push_back(fifo_din);
                beat_log.push_back(int'(fifo_din[31:24]));
            end
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    void'(txq[k].pop_front());
                    act[k] = 1'b0;
                end
            end
            if (!m_open) begin
                if (|req_valid) begin
                    m_who   = rr_model(m_prev, req_valid);
                    m_open  = 1'b1;
                    m_beats = 0;
                end
            end else if (!req_valid[m_who]) begin
                m_open = 1'b0;
                m_prev = m_who;
            end else if (!fifo_full) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_open = 1'b0;
                    m_prev = m_who;
                end
            end
        end else begin
            m_open = 1'b0;
            m_prev = NR - 1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = {NR{1'b0}};
        req_data  = {(NR*DW){1'b0}};
        fifo_full = 1'b0;

        // All requesters valid through reset, FIFO never full: fair 4-beat rotation.
        for (int k = 0; k < NR; k++) add_words(k, MB);
        rst_req_n = 1'b0;
        cycle();
        cycle();
        rst_req_n = 1'b1;
        beat_log.delete();
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (c == 1) check_eq("first_grant", grant_id, 0);
            if (c == 5) check_eq("bubble_idle", busy, 0);
            if (c == 6) check_eq("second_grant", grant_id, 1);
        end
        check_eq("beats_in_20", beat_log.size(), NR * MB);
        for (int i = 0; i < beat_log.size() && i < NR * MB; i++)
            check_eq("rr_order", beat_log[i], i / MB);

        // Lone requester 2 with 3 words, then requester 3 must win next.
        beat_log.delete();
        add_words(2, 3);
        for (int c = 0; c < 6; c++) cycle();
        check_eq("r2_beats", beat_log.size(), 3);
        for (int i = 0; i < beat_log.size(); i++) check_eq("r2_src", beat_log[i], 2);
        check_eq("r2_released", busy, 0);
        add_words(0, 2);
        add_words(1, 2);
        add_words(3, 2);
        cycle();
        cycle();
        check_eq("rr_after_r2", grant_id, 3);
        for (int c = 0; c < 20; c++) cycle();

        // FIFO full for 5 cycles after 2 beats of a burst.
        mode = 1;
        beat_log.delete();
        add_words(1, MB);
        for (int c = 0; c < 10 && beat_log.size() < 2; c++) cycle();
        check_eq("pre_stall_beats", beat_log.size(), 2);
        full_force = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check_eq("stall_wr_en", fifo_wr_en, 1'b0);
            check_eq("stall_ready", req_ready, {NR{1'b0}});
            check_eq("stall_busy", busy, 1'b1);
        end
        check_eq("stall_beats", beat_log.size(), 2);
        full_force = 1'b0;
        for (int c = 0; c < 10 && beat_log.size() < MB; c++) cycle();
        check_eq("post_stall_beats", beat_log.size(), MB);
        cycle();
        check_eq("burst_done", busy, 1'b0);

        // Reset during LOCK after one beat of requester 2.
        mode = 0;
        beat_log.delete();
        for (int k = 0; k < NR; k++) add_words(k, 6);
        for (int c = 0; c < 10 && beat_log.size() < 1; c++) cycle();
        check_eq("pre_rst_owner", grant_id, 2);
        rst_req_n = 1'b0;
        cycle();
        rst_req_n = 1'b1;
        cycle();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ready", req_ready, {NR{1'b0}});
        check_eq("rst_wr_en", fifo_wr_en, 1'b0);
        check_eq("rst_grant_id", grant_id, 0);
        cycle();
        check_eq("rst_regrant", grant_id, 0);
        check_eq("rst_regrant_busy", busy, 1'b1);
        for (int c = 0; c < 60; c++) cycle();

        // Random traffic into a depth-8 FIFO drained every other cycle.
        mode = 2;
        pct  = 50;
        for (int k = 0; k < NR; k++) add_words(k, 10 + int'($urandom_range(6)));
        for (int c = 0; c < 1500 && pending() > 0; c++) cycle();
        check_eq("drain_done", pending(), 0);
        for (int k = 0; k < NR; k++) check_eq("sb_missing", expq[k].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
